// File: rtl/fifo_ctrl.sv
// Pointer/flag controller for a synchronous FIFO built around fifo_core.
// Qualifies push/pop against full/empty and tracks occupancy plus sticky errors.
module fifo_ctrl #(
  parameter int ADDR_WIDTH    = 4,
  parameter int AFULL_THRESH  = 14,
  parameter int AEMPTY_THRESH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic                  pop,
  input  logic                  clr_err,
  output logic                  wr_en,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] wr_ptr,
  output logic [ADDR_WIDTH-1:0] rd_ptr,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam logic [ADDR_WIDTH:0] AFULL_LVL  = (ADDR_WIDTH+1)'(AFULL_THRESH);
  localparam logic [ADDR_WIDTH:0] AEMPTY_LVL = (ADDR_WIDTH+1)'(AEMPTY_THRESH);

  logic [ADDR_WIDTH:0] wp;
  logic [ADDR_WIDTH:0] rp;
  logic                ovf_evt;
  logic                udf_evt;

  // Flags depend only on the registered pointers, never on push/pop.
  assign count        = wp - rp;
  assign empty        = (wp == rp);
  assign full         = (wp[ADDR_WIDTH] != rp[ADDR_WIDTH]) &&
                        (wp[ADDR_WIDTH-1:0] == rp[ADDR_WIDTH-1:0]);
  assign almost_full  = (count >= AFULL_LVL);
  assign almost_empty = (count <= AEMPTY_LVL);
  assign wr_ptr       = wp[ADDR_WIDTH-1:0];
  assign rd_ptr       = rp[ADDR_WIDTH-1:0];

  // A pop frees a slot in the same cycle, so a push into a full FIFO is accepted with it.
  assign rd_en   = pop & ~empty;
  assign wr_en   = push & (~full | pop);
  assign ovf_evt = push & full & ~pop;
  assign udf_evt = pop & empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      wp        <= '0;
      rp        <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      wp <= wp + {{ADDR_WIDTH{1'b0}}, wr_en};
      rp <= rp + {{ADDR_WIDTH{1'b0}}, rd_en};
      // A fresh error outranks a simultaneous clear.
      if (ovf_evt)
        overflow <= 1'b1;
      else if (clr_err)
        overflow <= 1'b0;
      if (udf_evt)
        underflow <= 1'b1;
      else if (clr_err)
        underflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fifo_ctrl.sv
// Scoreboard bench for fifo_ctrl: a small reference model queues expected status and read data,
// and a monitor on the falling edge pops and compares them against the DUT.
module tb_fifo_ctrl;

  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       push = 1'b0;
  logic       pop = 1'b0;
  logic       clr_err = 1'b0;
  logic [7:0] din = 8'h00;
  logic       wr_en, rd_en, full, empty, almost_full, almost_empty, overflow, underflow;
  logic [3:0] wr_ptr, rd_ptr;
  logic [4:0] count;

  typedef struct {
    logic       wr;
    logic       rd;
    logic       full;
    logic       empty;
    logic       af;
    logic       ae;
    logic       ovf;
    logic       udf;
    logic [4:0] cnt;
    logic [3:0] wp;
    logic [3:0] rp;
  } exp_t;

  exp_t       status_q[$];
  logic [7:0] data_q[$];
  logic [7:0] model_q[$];
  logic [7:0] mem [DEPTH];
  logic [4:0] wpm = '0;
  logic [4:0] rpm = '0;
  logic       ovfm = 1'b0;
  logic       udfm = 1'b0;
  int         checks = 0;
  int         fails = 0;

  fifo_ctrl #(.ADDR_WIDTH(4), .AFULL_THRESH(14), .AEMPTY_THRESH(2)) dut (
    .clk(clk), .rst(rst), .push(push), .pop(pop), .clr_err(clr_err),
    .wr_en(wr_en), .rd_en(rd_en), .wr_ptr(wr_ptr), .rd_ptr(rd_ptr),
    .full(full), .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty),
    .count(count), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  // Stand-in for fifo_core storage: written at the edge, read combinationally.
  always @(posedge clk) if (wr_en) mem[wr_ptr] <= din;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle at posedge+1, queue the expected status, then advance the model.
  task automatic applyStimulus(input logic p, input logic q, input logic c, input logic r,
                               input logic [7:0] d);
    exp_t e;
    int   n;
    push = p; pop = q; clr_err = c; rst = r; din = d;
    n = model_q.size();
    e.rd = q && (n != 0);
    e.wr = p && ((n != DEPTH) || q);
    e.full = (n == DEPTH); e.empty = (n == 0);
    e.af = (n >= 14); e.ae = (n <= 2);
    e.ovf = ovfm; e.udf = udfm;
    e.cnt = 5'(n); e.wp = wpm[3:0]; e.rp = rpm[3:0];
    status_q.push_back(e);
    if (e.rd) begin
      data_q.push_back(model_q.pop_front());
      rpm = rpm + 5'd1;
    end
    if (e.wr) begin
      model_q.push_back(d);
      wpm = wpm + 5'd1;
    end
    if (p && (n == DEPTH) && !q) ovfm = 1'b1; else if (c) ovfm = 1'b0;
    if (q && (n == 0)) udfm = 1'b1; else if (c) udfm = 1'b0;
    if (r) begin
      model_q.delete();
      wpm = '0; rpm = '0; ovfm = 1'b0; udfm = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare queued expectations mid-cycle, away from the active edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (status_q.size() > 0) begin
        e = status_q.pop_front();
        checkOutput("wr_en", 32'(wr_en), 32'(e.wr));
        checkOutput("rd_en", 32'(rd_en), 32'(e.rd));
        checkOutput("full", 32'(full), 32'(e.full));
        checkOutput("empty", 32'(empty), 32'(e.empty));
        checkOutput("almost_full", 32'(almost_full), 32'(e.af));
        checkOutput("almost_empty", 32'(almost_empty), 32'(e.ae));
        checkOutput("overflow", 32'(overflow), 32'(e.ovf));
        checkOutput("underflow", 32'(underflow), 32'(e.udf));
        checkOutput("count", 32'(count), 32'(e.cnt));
        checkOutput("wr_ptr", 32'(wr_ptr), 32'(e.wp));
        checkOutput("rd_ptr", 32'(rd_ptr), 32'(e.rp));
      end
      if (rd_en === 1'b1) begin
        if (data_q.size() == 0)
          checkOutput("dout_unexpected_read", 32'(1), 32'(0));
        else
          checkOutput("dout", 32'(mem[rd_ptr]), 32'(data_q.pop_front()));
      end
    end
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    // Reset state, then one more reset cycle and an idle cycle.
    applyStimulus(0, 0, 0, 0, 8'h00);
    applyStimulus(1, 0, 0, 1, 8'hAA);
    applyStimulus(0, 0, 0, 0, 8'h00);
    checkOutput("reset_count", 32'(count), 32'd0);
    checkOutput("reset_empty", 32'(empty), 32'd1);

    // Fill to full, then one rejected push.
    for (int i = 0; i < 16; i++) applyStimulus(1, 0, 0, 0, 8'(i));
    applyStimulus(1, 0, 0, 0, 8'h10);
    checkOutput("fill_count", 32'(count), 32'd16);
    checkOutput("fill_full", 32'(full), 32'd1);
    checkOutput("fill_overflow", 32'(overflow), 32'd1);

    // Drain, one rejected pop, then clear errors.
    for (int i = 0; i < 16; i++) applyStimulus(0, 1, 0, 0, 8'h00);
    applyStimulus(0, 1, 0, 0, 8'h00);
    checkOutput("drain_underflow", 32'(underflow), 32'd1);
    checkOutput("drain_empty", 32'(empty), 32'd1);
    applyStimulus(0, 0, 1, 0, 8'h00);
    checkOutput("clr_overflow", 32'(overflow), 32'd0);
    checkOutput("clr_underflow", 32'(underflow), 32'd0);

    // Full with push and pop together for four cycles.
    for (int i = 0; i < 16; i++) applyStimulus(1, 0, 0, 0, 8'(8'h20 + i));
    for (int i = 0; i < 4; i++) applyStimulus(1, 1, 0, 0, 8'(8'h40 + i));
    checkOutput("simul_full_count", 32'(count), 32'd16);
    checkOutput("simul_wr_ptr", 32'(wr_ptr), 32'd4);
    checkOutput("simul_rd_ptr", 32'(rd_ptr), 32'd4);
    checkOutput("simul_overflow", 32'(overflow), 32'd0);
    for (int i = 0; i < 16; i++) applyStimulus(0, 1, 0, 0, 8'h00);

    // Empty with push and pop together: push wins, pop flags underflow.
    applyStimulus(1, 1, 0, 0, 8'h55);
    checkOutput("simul_empty_count", 32'(count), 32'd1);
    checkOutput("simul_empty_underflow", 32'(underflow), 32'd1);
    applyStimulus(0, 1, 1, 0, 8'h00);
    checkOutput("clr_after_simul", 32'(underflow), 32'd0);

    // Error set and clear in the same cycle: set wins.
    applyStimulus(0, 1, 1, 0, 8'h00);
    checkOutput("set_beats_clear", 32'(underflow), 32'd1);
    applyStimulus(0, 0, 1, 0, 8'h00);

    // Wrap at occupancy 3 with 40 simultaneous push/pop cycles.
    for (int i = 0; i < 3; i++) applyStimulus(1, 0, 0, 0, 8'(8'h80 + i));
    for (int i = 0; i < 40; i++) applyStimulus(1, 1, 0, 0, 8'(8'h90 + i));
    checkOutput("wrap_count", 32'(count), 32'd3);
    checkOutput("wrap_overflow", 32'(overflow), 32'd0);
    checkOutput("wrap_underflow", 32'(underflow), 32'd0);

    // Reset at count 9 with push held.
    for (int i = 0; i < 6; i++) applyStimulus(1, 0, 0, 0, 8'(8'hC0 + i));
    checkOutput("pre_reset_count", 32'(count), 32'd9);
    applyStimulus(1, 0, 0, 1, 8'hEE);
    checkOutput("midreset_count", 32'(count), 32'd0);
    checkOutput("midreset_empty", 32'(empty), 32'd1);
    applyStimulus(0, 0, 0, 0, 8'h00);

    repeat (3) @(negedge clk);
    checkOutput("status_queue_drained", 32'(status_q.size()), 32'd0);
    checkOutput("data_queue_drained", 32'(data_q.size()), 32'd0);
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
